scan_chain_loader: RTL and testbench

//  Sequences a configuration scan chain of an FPGA core. Accepts bitstream words over a valid/ready stream.

---
 rtl/scan_chain_loader.sv | 161 ++++++++++++++++
 tb/tb_scan_chain_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_loader.sv
// Configuration scan-chain sequencer: streams words LSB-first onto the chain
// for exactly SC_LENGTH shifts, or runs a timed active-low wipe of the chain.
module scan_chain_loader #(
  parameter int unsigned SC_LENGTH    = 1024,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned CLEAR_CYCLES = 2,
  localparam int unsigned CNT_W       = $clog2(SC_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  wipe,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  sc_en,
  output logic                  sc_data,
  output logic                  sc_clear,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count
);

  localparam int unsigned LEFT_W = $clog2(WORD_WIDTH + 1);
  localparam int unsigned WC_W   = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WIPE, S_FINISH} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] sr_q, sr_d;
  logic [LEFT_W-1:0]     left_q, left_d;
  logic [CNT_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      bit_count_q, bit_count_d;
  logic [WC_W-1:0]       wcnt_q, wcnt_d;
  logic                  word_ready_q, word_ready_d;
  logic                  sc_en_q, sc_en_d;
  logic                  sc_data_q, sc_data_d;
  logic                  sc_clear_q, sc_clear_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  xfer;
  logic [CNT_W-1:0]      avail;
  logic [31:0]           use_bits;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    left_d       = left_q;
    acc_d        = acc_q;
    bit_count_d  = bit_count_q;
    wcnt_d       = wcnt_q;
    word_ready_d = 1'b0;
    sc_en_d      = 1'b0;
    sc_data_d    = 1'b0;
    sc_clear_d   = 1'b1;
    done_d       = 1'b0;

    xfer  = word_valid && word_ready_q;
    avail = CNT_W'(SC_LENGTH) - acc_q;
    // The final word only contributes the bits still missing from the chain.
    if (32'(avail) < WORD_WIDTH) use_bits = 32'(avail);
    else                         use_bits = WORD_WIDTH;

    unique case (state_q)
      S_IDLE: begin
        if (wipe) begin
          state_d    = S_WIPE;
          wcnt_d     = '0;
          sc_clear_d = 1'b0;
        end else if (start) begin
          state_d      = S_SHIFT;
          bit_count_d  = '0;
          acc_d        = '0;
          left_d       = '0;
          word_ready_d = 1'b1;
        end
      end

      S_SHIFT: begin
        if (sc_en_q && (bit_count_q != CNT_W'(SC_LENGTH)))
          bit_count_d = bit_count_q + 1'b1;
        if (sc_en_q && (bit_count_q == CNT_W'(SC_LENGTH - 1))) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          if (xfer) begin
            sc_en_d   = 1'b1;
            sc_data_d = word_i[0];
            sr_d      = word_i >> 1;
            left_d    = LEFT_W'(use_bits - 32'd1);
            acc_d     = acc_q + CNT_W'(use_bits);
          end else if (left_q != '0) begin
            sc_en_d   = 1'b1;
            sc_data_d = sr_q[0];
            sr_d      = sr_q >> 1;
            left_d    = left_q - 1'b1;
          end
          // Ready whenever the next cycle presents the held word's last bit
          // (or nothing), so consecutive words stream without a bubble.
          word_ready_d = (left_d == '0) && (acc_d < CNT_W'(SC_LENGTH));
        end
      end

      S_WIPE: begin
        if (wcnt_q == WC_W'(CLEAR_CYCLES - 1)) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          wcnt_d     = wcnt_q + 1'b1;
          sc_clear_d = 1'b0;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      left_q       <= '0;
      acc_q        <= '0;
      bit_count_q  <= '0;
      wcnt_q       <= '0;
      word_ready_q <= 1'b0;
      sc_en_q      <= 1'b0;
      sc_data_q    <= 1'b0;
      sc_clear_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      left_q       <= left_d;
      acc_q        <= acc_d;
      bit_count_q  <= bit_count_d;
      wcnt_q       <= wcnt_d;
      word_ready_q <= word_ready_d;
      sc_en_q      <= sc_en_d;
      sc_data_q    <= sc_data_d;
      sc_clear_q   <= sc_clear_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign word_ready = word_ready_q;
  assign sc_en      = sc_en_q;
  assign sc_data    = sc_data_q;
  assign sc_clear   = sc_clear_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: per-cycle vector table plus load/stall/reset
// sequences against a behavioural scan chain.
module tb_scan_chain_loader;

  logic       clk = 1'b0;
  logic       clear;
  logic       start, wipe, word_valid;
  logic [3:0] word_i;
  logic       word_ready, sc_en, sc_data, sc_clear, busy, done;
  logic [3:0] bit_count;

  logic       start2, word_valid2;
  logic [3:0] word_i2;
  logic       word_ready2, sc_en2, sc_data2, sc_clear2, busy2, done2;
  logic [3:0] bit_count2;

  logic [9:0] chain;
  logic [7:0] chain2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scan_chain_loader #(.SC_LENGTH(10), .WORD_WIDTH(4), .CLEAR_CYCLES(2)) dut (
    .clk(clk), .clear(clear), .start(start), .wipe(wipe), .word_i(word_i),
    .word_valid(word_valid), .word_ready(word_ready), .sc_en(sc_en),
    .sc_data(sc_data), .sc_clear(sc_clear), .busy(busy), .done(done),
    .bit_count(bit_count)
  );

  scan_chain_loader #(.SC_LENGTH(8), .WORD_WIDTH(4), .CLEAR_CYCLES(2)) dut2 (
    .clk(clk), .clear(clear), .start(start2), .wipe(1'b0), .word_i(word_i2),
    .word_valid(word_valid2), .word_ready(word_ready2), .sc_en(sc_en2),
    .sc_data(sc_data2), .sc_clear(sc_clear2), .busy(busy2), .done(done2),
    .bit_count(bit_count2)
  );

  // Behavioural chain: data enters at the top, so stream bit k lands at position k.
  always @(posedge clk) begin
    if (!sc_clear)  chain <= '0;
    else if (sc_en) chain <= {sc_data, chain[9:1]};
    if (!sc_clear2)  chain2 <= '0;
    else if (sc_en2) chain2 <= {sc_data2, chain2[7:1]};
  end

  always @(negedge clk) begin
    if (sc_en && !sc_clear) begin
      n_fail++;
      $display("FAIL en_during_clear: sc_en=1 while sc_clear=0 at %0t", $time);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       start, wipe, valid;
    logic [3:0] word;
    logic       rdy, en, data, clr, bsy, dn;
    logic [3:0] bc;
  } vec_t;

  function automatic vec_t mk(input logic s, w, v, input logic [3:0] wd,
                              input logic r, e, d, c, b, dn, input logic [3:0] bc);
    vec_t t;
    t.start = s; t.wipe = w; t.valid = v; t.word = wd;
    t.rdy = r; t.en = e; t.data = d; t.clr = c; t.bsy = b; t.dn = dn; t.bc = bc;
    return t;
  endfunction

  vec_t       vt[21];
  logic [3:0] words[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full load with optional ready-stall of 'gap' cycles after the first word
  // and an optional stray start pulse mid-load.
  task automatic load_run(input string tag, input int gap, input bit poke);
    int  idx = 0, en_cnt = 0, low = 0, stall_bad = 0, gap_cnt = 0;
    bit  gap_used = 0, got_done = 0, prev_en = 0, done_after_en = 0, xfer;
    start = 1'b1; word_valid = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin got_done = 1; done_after_en = prev_en; break; end
      if (!sc_en && en_cnt > 0) begin
        low++;
        if (bit_count != 4'(en_cnt)) stall_bad++;
      end
      if (sc_en) en_cnt++;
      prev_en = sc_en;
      start = (poke && c == 6);
      if (idx == 1 && !gap_used && word_ready) begin gap_cnt = gap; gap_used = 1; end
      word_valid = (idx < 4) && (gap_cnt == 0);
      word_i     = words[idx < 4 ? idx : 3];
      if (gap_cnt > 0) gap_cnt--;
      xfer = word_valid && word_ready;
      step();
      if (xfer) idx++;
    end
    start = 1'b0; word_valid = 1'b0;
    check({tag, " done_seen"}, 32'(got_done), 1);
    check({tag, " done_after_last_shift"}, 32'(done_after_en), 1);
    check({tag, " shifts"}, en_cnt, 10);
    check({tag, " stall_cycles"}, low, gap);
    check({tag, " stall_bc_hold_errors"}, stall_bad, 0);
    check({tag, " words_accepted"}, idx, 3);
    check({tag, " bit_count"}, 32'(bit_count), 10);
    check({tag, " chain"}, 32'(chain), 32'h3A5);
    step();
    check({tag, " idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int en_cnt, idx;
    bit xfer, got_done;

    words[0] = 4'h5; words[1] = 4'hA; words[2] = 4'h3; words[3] = 4'hF;

    //            s  w  v  word  rdy en d clr bsy dn bc
    vt[0]  = mk(1, 0, 0, 4'h0, 1, 0, 0, 1, 1, 0, 4'd0);
    vt[1]  = mk(0, 0, 1, 4'h5, 0, 1, 1, 1, 1, 0, 4'd0);
    vt[2]  = mk(0, 0, 1, 4'hA, 0, 1, 0, 1, 1, 0, 4'd1);
    vt[3]  = mk(0, 0, 1, 4'hA, 0, 1, 1, 1, 1, 0, 4'd2);
    vt[4]  = mk(0, 0, 1, 4'hA, 1, 1, 0, 1, 1, 0, 4'd3);
    vt[5]  = mk(0, 0, 1, 4'hA, 0, 1, 0, 1, 1, 0, 4'd4);
    vt[6]  = mk(0, 0, 1, 4'h3, 0, 1, 1, 1, 1, 0, 4'd5);
    vt[7]  = mk(0, 0, 1, 4'h3, 0, 1, 0, 1, 1, 0, 4'd6);
    vt[8]  = mk(0, 0, 1, 4'h3, 1, 1, 1, 1, 1, 0, 4'd7);
    vt[9]  = mk(0, 0, 1, 4'h3, 0, 1, 1, 1, 1, 0, 4'd8);
    vt[10] = mk(0, 0, 1, 4'hF, 0, 1, 1, 1, 1, 0, 4'd9);
    vt[11] = mk(0, 0, 1, 4'hF, 0, 0, 0, 1, 1, 1, 4'd10);
    vt[12] = mk(0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 4'd10);
    vt[13] = mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'd10);
    vt[14] = mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'd10);
    vt[15] = mk(0, 0, 0, 4'h0, 0, 0, 0, 1, 1, 1, 4'd10);
    vt[16] = mk(0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 4'd10);
    vt[17] = mk(1, 1, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'd10);
    vt[18] = mk(1, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 4'd10);
    vt[19] = mk(0, 0, 0, 4'h0, 0, 0, 0, 1, 1, 1, 4'd10);
    vt[20] = mk(0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 4'd10);

    clear = 1'b0; start = 1'b0; wipe = 1'b0; word_valid = 1'b0; word_i = '0;
    start2 = 1'b0; word_valid2 = 1'b0; word_i2 = '0;
    step(); step();
    check("reset outputs", {word_ready, sc_en, sc_data, sc_clear, busy, done, bit_count},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
    clear = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      start = vt[i].start; wipe = vt[i].wipe; word_valid = vt[i].valid; word_i = vt[i].word;
      step();
      check($sformatf("vec%0d ready/en/clr/busy/done/bc", i),
            {word_ready, sc_en, sc_clear, busy, done, bit_count},
            {vt[i].rdy, vt[i].en, vt[i].clr, vt[i].bsy, vt[i].dn, vt[i].bc});
      if (vt[i].en) check($sformatf("vec%0d sc_data", i), 32'(sc_data), 32'(vt[i].data));
      if (i == 12) check("load chain", 32'(chain), 32'h3A5);
      if (i == 16) check("wipe chain", 32'(chain), 32'h0);
    end
    start = 1'b0; wipe = 1'b0; word_valid = 1'b0;
    step();

    load_run("stall", 3, 1'b1);

    // Reset in the middle of a load, then a clean reload.
    start = 1'b1;
    step();
    start = 1'b0;
    en_cnt = 0; idx = 0;
    for (int c = 0; c < 30; c++) begin
      if (sc_en) en_cnt++;
      if (en_cnt == 5) break;
      word_valid = 1'b1; word_i = words[idx < 4 ? idx : 3];
      xfer = word_ready;
      step();
      if (xfer) idx++;
    end
    check("abort shifts_before_clear", en_cnt, 5);
    clear = 1'b0;
    step();
    check("abort outputs", {sc_en, sc_clear, busy, word_ready, done, bit_count},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    clear = 1'b1; word_valid = 1'b0;
    step();
    load_run("reload", 0, 1'b0);

    // Chain length an exact multiple of the word width.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    en_cnt = 0; idx = 0; got_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done2) begin got_done = 1; break; end
      if (sc_en2) en_cnt++;
      word_valid2 = 1'b1;
      word_i2 = (idx == 0) ? 4'hC : (idx == 1) ? 4'h3 : 4'hF;
      xfer = word_ready2;
      step();
      if (xfer) idx++;
    end
    word_valid2 = 1'b0;
    check("len8 done_seen", 32'(got_done), 1);
    check("len8 words_accepted", idx, 2);
    check("len8 shifts", en_cnt, 8);
    check("len8 chain", 32'(chain2), 32'h3C);
    check("len8 bit_count", 32'(bit_count2), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
